// File: rtl/calc2_pkg.sv
// Shared definitions for the calc2 port master: command and response codes,
// issue-FSM states and the response-FIFO entry format.
package calc2_pkg;

  localparam logic [3:0] CMD_NOP = 4'h0;
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  localparam logic [1:0] RESP_NONE     = 2'd0;
  localparam logic [1:0] RESP_OK       = 2'd1;
  localparam logic [1:0] RESP_OVF      = 2'd2;
  localparam logic [1:0] RESP_INVALID  = 2'd2;
  localparam logic [1:0] RESP_INTERNAL = 2'd3;

  localparam int NUM_TAGS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND1 = 2'd1,
    ST_SEND2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    logic [3:0]  cmd;
  } rsp_entry_t;

  // Returns {none_free, tag}: the lowest-numbered clear bit of busy.
  function automatic logic [2:0] lowest_free_tag(input logic [3:0] busy);
    logic [2:0] sel;
    sel = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (!busy[i]) sel = {1'b0, 2'(i)};
    end
    return sel;
  endfunction

endpackage

// File: rtl/calc2_port_master_if.sv
// Op, calc2-port and result signals of one calc2 port master, grouped with
// master (block side) and slave (environment side) modports.
interface calc2_port_master_if;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;

  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  req_tag_out;

  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic [3:0]  rsp_cmd;

  logic        err_unexpected;

  modport master (
    input  op_valid, op_cmd, op_data1, op_data2,
    output op_ready,
    output req_cmd_out, req_data_out, req_tag_out,
    input  out_resp, out_data, out_tag,
    output rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_cmd,
    input  rsp_ready,
    output err_unexpected
  );

  modport slave (
    output op_valid, op_cmd, op_data1, op_data2,
    input  op_ready,
    input  req_cmd_out, req_data_out, req_tag_out,
    output out_resp, out_data, out_tag,
    input  rsp_valid, rsp_resp, rsp_data, rsp_tag, rsp_cmd,
    output rsp_ready,
    input  err_unexpected
  );
endinterface

// File: rtl/calc2_rsp_fifo.sv
// Response FIFO holding completed calc2 results in arrival order; the head
// is read combinationally so it can be presented without a bubble.
module calc2_rsp_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       c_clk,
  input  logic                       reset,
  input  logic                       push,
  input  rsp_entry_t                 push_entry,
  input  logic                       pop,
  output rsp_entry_t                 head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rsp_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  assign head  = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/calc2_port_master.sv
// Drives one calc2 port: issues each op as a two-beat request with a tag,
// tracks outstanding tags and queues returning responses for a downstream consumer.
module calc2_port_master
  import calc2_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 4
) (
  input logic                 c_clk,
  input logic                 reset,
  calc2_port_master_if.master bus
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_t              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [31:0]         data1_q, data1_d;
  logic [31:0]         data2_q, data2_d;
  logic [1:0]          tag_q, tag_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [3:0]          tbl_cmd_q [NUM_TAGS];
  logic [3:0]          tbl_cmd_d [NUM_TAGS];
  logic                err_q, err_d;

  logic [2:0]          free_sel;
  logic [2:0]          outstanding;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_empty;
  rsp_entry_t          fifo_head, push_entry, rsp_out;
  logic                op_ready, accept, rsp_seen, tag_busy, push, pop;
  logic [3:0]          req_cmd;
  logic [31:0]         req_data;
  logic [1:0]          req_tag;

  assign free_sel = lowest_free_tag(busy_q);

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_TAGS; i++) outstanding = outstanding + 3'(busy_q[i]);
  end

  // Credit rule: every outstanding op has a FIFO slot reserved for its response.
  assign op_ready = !reset && (state_q != ST_SEND1) && !free_sel[2]
                 && (int'(outstanding) < MAX_OUTSTANDING)
                 && (int'(outstanding) + int'(fifo_count) < RSP_DEPTH);
  assign accept   = bus.op_valid && op_ready;

  assign rsp_seen   = (bus.out_resp != RESP_NONE);
  assign tag_busy   = busy_q[bus.out_tag];
  assign push       = rsp_seen && tag_busy;
  assign pop        = !fifo_empty && bus.rsp_ready;
  assign push_entry = '{resp: bus.out_resp, data: bus.out_data,
                        tag: bus.out_tag, cmd: tbl_cmd_q[bus.out_tag]};

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    tag_d     = tag_q;
    busy_d    = busy_q;
    tbl_cmd_d = tbl_cmd_q;
    err_d     = err_q;
    req_cmd   = CMD_NOP;
    req_data  = '0;
    req_tag   = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SEND1;
      end
      ST_SEND1: begin
        req_cmd  = cmd_q;
        req_data = data1_q;
        req_tag  = tag_q;
        state_d  = ST_SEND2;
      end
      ST_SEND2: begin
        req_cmd  = CMD_NOP;
        req_data = data2_q;
        req_tag  = tag_q;
        state_d  = accept ? ST_SEND1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      cmd_d                     = bus.op_cmd;
      data1_d                   = bus.op_data1;
      data2_d                   = bus.op_data2;
      tag_d                     = free_sel[1:0];
      busy_d[free_sel[1:0]]     = 1'b1;
      tbl_cmd_d[free_sel[1:0]]  = bus.op_cmd;
    end
    // Accept only ever picks a tag that is free in busy_q, so it never collides with this clear.
    if (push) busy_d[bus.out_tag] = 1'b0;
    if (rsp_seen && !tag_busy) err_d = 1'b1;
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      tag_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < NUM_TAGS; i++) tbl_cmd_q[i] <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      tbl_cmd_q <= tbl_cmd_d;
      err_q     <= err_d;
    end
  end

  calc2_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .c_clk      (c_clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign rsp_out = fifo_empty ? '0 : fifo_head;

  assign bus.op_ready       = op_ready;
  assign bus.req_cmd_out    = req_cmd;
  assign bus.req_data_out   = req_data;
  assign bus.req_tag_out    = req_tag;
  assign bus.rsp_valid      = !fifo_empty;
  assign bus.rsp_resp       = rsp_out.resp;
  assign bus.rsp_data       = rsp_out.data;
  assign bus.rsp_tag        = rsp_out.tag;
  assign bus.rsp_cmd        = rsp_out.cmd;
  assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_calc2_port_master.sv
// Directed bench for calc2_port_master: expected responses go into a
// scoreboard queue and a monitor compares every popped result against it.
module tb_calc2_port_master;
  import calc2_pkg::*;

  logic c_clk = 1'b0;
  logic reset = 1'b1;

  calc2_port_master_if bus ();

  calc2_port_master #(
    .MAX_OUTSTANDING (4),
    .RSP_DEPTH       (4)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [39:0] sb_q [$];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void expect_rsp(logic [1:0] resp, logic [31:0] data,
                                     logic [1:0] tag, logic [3:0] cmd);
    sb_q.push_back({resp, data, tag, cmd});
  endfunction

  // Monitor: one comparison per popped result
  always @(negedge c_clk) begin : monitor
    logic [39:0] got;
    logic [39:0] want;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      got = {bus.rsp_resp, bus.rsp_data, bus.rsp_tag, bus.rsp_cmd};
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_extra: got 0x%0h want no result", got);
      end else begin
        want = sb_q.pop_front();
        chk("rsp", 64'(got), 64'(want));
        $display("rsp: resp=%0d data=0x%0h tag=%0d cmd=%0d",
                 bus.rsp_resp, bus.rsp_data, bus.rsp_tag, bus.rsp_cmd);
      end
    end
  end

  function automatic logic [63:0] req_now();
    return 64'({bus.req_cmd_out, bus.req_data_out, bus.req_tag_out});
  endfunction

  // Offers one op, waits (bounded) for acceptance, then checks both request beats.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [1:0] exp_tag, input string nm);
    int n;
    n = 0;
    bus.op_valid = 1'b1;
    bus.op_cmd   = cmd;
    bus.op_data1 = d1;
    bus.op_data2 = d2;
    @(negedge c_clk);
    while (!bus.op_ready && n < 50) begin
      @(negedge c_clk);
      n++;
    end
    if (!bus.op_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: op_ready stayed 0 for %0d cycles, want 1", nm, n);
      bus.op_valid = 1'b0;
      return;
    end
    @(posedge c_clk);
    #1;
    bus.op_valid = 1'b0;
    chk({nm, "_send1"}, req_now(), 64'({cmd, d1, exp_tag}));
    @(posedge c_clk);
    #1;
    chk({nm, "_send2"}, req_now(), 64'({4'h0, d2, exp_tag}));
    $display("op %s: cmd=%0d d1=0x%0h d2=0x%0h tag=%0d", nm, cmd, d1, d2, bus.req_tag_out);
  endtask

  task automatic inject(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
    bus.out_resp = resp;
    bus.out_data = data;
    bus.out_tag  = tag;
    @(posedge c_clk);
    #1;
    bus.out_resp = 2'd0;
    bus.out_data = '0;
    bus.out_tag  = 2'd0;
  endtask

  task automatic respond(input logic [1:0] resp, input logic [31:0] data,
                         input logic [1:0] tag, input logic [3:0] cmd);
    expect_rsp(resp, data, tag, cmd);
    inject(resp, data, tag);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge c_clk);
      n++;
    end
    #1;
    chk({nm, "_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.op_valid  = 1'b0;
    bus.op_cmd    = 4'h0;
    bus.op_data1  = '0;
    bus.op_data2  = '0;
    bus.out_resp  = 2'd0;
    bus.out_data  = '0;
    bus.out_tag   = 2'd0;
    bus.rsp_ready = 1'b1;

    // Reset state
    #1;
    chk("reset_req", req_now(), 64'd0);
    chk("reset_op_ready", 64'(bus.op_ready), 64'd0);
    chk("reset_rsp", 64'({bus.rsp_valid, bus.rsp_resp, bus.rsp_data, bus.rsp_tag, bus.rsp_cmd}), 64'd0);
    chk("reset_err", 64'(bus.err_unexpected), 64'd0);
    repeat (2) @(posedge c_clk);
    @(negedge c_clk);
    reset = 1'b0;
    #1;
    chk("release_op_ready", 64'(bus.op_ready), 64'd1);
    @(posedge c_clk);
    #1;

    // Single ADD and its response
    issue(CMD_ADD, 32'h56, 32'h103, 2'd0, "add");
    @(posedge c_clk);
    #1;
    chk("idle_req", req_now(), 64'd0);
    respond(RESP_OK, 32'h159, 2'd0, CMD_ADD);
    wait_drain("add");

    // Back-to-back SUBs, second accepted during SEND2
    @(posedge c_clk);
    #1;
    bus.op_valid = 1'b1;
    bus.op_cmd   = CMD_SUB;
    bus.op_data1 = 32'h158;
    bus.op_data2 = 32'h12;
    @(negedge c_clk);
    chk("b2b_ready_idle", 64'(bus.op_ready), 64'd1);
    @(posedge c_clk);
    #1;
    chk("b2b_a_send1", req_now(), 64'({CMD_SUB, 32'h158, 2'd0}));
    bus.op_data1 = 32'h18;
    bus.op_data2 = 32'h32;
    @(negedge c_clk);
    chk("b2b_ready_send1", 64'(bus.op_ready), 64'd0);
    @(posedge c_clk);
    #1;
    chk("b2b_a_send2", req_now(), 64'({4'h0, 32'h12, 2'd0}));
    @(negedge c_clk);
    chk("b2b_ready_send2", 64'(bus.op_ready), 64'd1);
    @(posedge c_clk);
    #1;
    bus.op_valid = 1'b0;
    chk("b2b_b_send1", req_now(), 64'({CMD_SUB, 32'h18, 2'd1}));
    @(posedge c_clk);
    #1;
    chk("b2b_b_send2", req_now(), 64'({4'h0, 32'h32, 2'd1}));
    @(posedge c_clk);
    #1;
    respond(RESP_OK, 32'h146, 2'd0, CMD_SUB);
    respond(RESP_OVF, 32'h0, 2'd1, CMD_SUB);
    wait_drain("b2b");

    // Tag exhaustion, then reuse of a freed tag
    issue(CMD_ADD, 32'h1, 32'h2, 2'd0, "t0");
    issue(CMD_SUB, 32'h9, 32'h4, 2'd1, "t1");
    issue(CMD_SHL, 32'h1, 32'h3, 2'd2, "t2");
    issue(CMD_SHR, 32'h40, 32'h2, 2'd3, "t3");
    bus.op_valid = 1'b1;
    bus.op_cmd   = CMD_ADD;
    bus.op_data1 = 32'h100;
    bus.op_data2 = 32'h1;
    @(negedge c_clk);
    chk("tags_exhausted_ready", 64'(bus.op_ready), 64'd0);
    @(posedge c_clk);
    #1;
    expect_rsp(RESP_OK, 32'h8, 2'd2, CMD_SHL);
    bus.out_resp = RESP_OK;
    bus.out_data = 32'h8;
    bus.out_tag  = 2'd2;
    @(negedge c_clk);
    chk("freed_same_cycle_ready", 64'(bus.op_ready), 64'd0);
    @(posedge c_clk);
    #1;
    bus.out_resp = 2'd0;
    bus.out_data = '0;
    bus.out_tag  = 2'd0;
    issue(CMD_ADD, 32'h100, 32'h1, 2'd2, "t2_reuse");
    respond(RESP_OK, 32'h3, 2'd0, CMD_ADD);
    respond(RESP_OK, 32'h5, 2'd1, CMD_SUB);
    respond(RESP_OK, 32'h10, 2'd3, CMD_SHR);
    respond(RESP_OK, 32'h101, 2'd2, CMD_ADD);
    wait_drain("exhaust");

    // Backpressure: FIFO fills, results leave in arrival order
    bus.rsp_ready = 1'b0;
    issue(CMD_ADD, 32'h10, 32'h20, 2'd0, "bp0");
    issue(CMD_SUB, 32'h50, 32'h8, 2'd1, "bp1");
    issue(CMD_SHL, 32'h1, 32'h4, 2'd2, "bp2");
    issue(CMD_SHR, 32'h80, 32'h3, 2'd3, "bp3");
    respond(RESP_OK, 32'h10, 2'd2, CMD_SHL);
    respond(RESP_OK, 32'h30, 2'd0, CMD_ADD);
    respond(RESP_OK, 32'h10, 2'd3, CMD_SHR);
    respond(RESP_OK, 32'h48, 2'd1, CMD_SUB);
    bus.op_valid = 1'b1;
    bus.op_cmd   = CMD_ADD;
    bus.op_data1 = 32'h7;
    bus.op_data2 = 32'h7;
    @(negedge c_clk);
    chk("bp_full_ready", 64'(bus.op_ready), 64'd0);
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    repeat (3) @(negedge c_clk);
    chk("bp_full_ready_held", 64'(bus.op_ready), 64'd0);
    @(posedge c_clk);
    #1;
    bus.op_valid  = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_drain("bp");

    // Response on a tag that is not outstanding
    @(posedge c_clk);
    #1;
    inject(RESP_OK, 32'h77, 2'd3);
    chk("unexp_err", 64'(bus.err_unexpected), 64'd1);
    chk("unexp_no_push", 64'(bus.rsp_valid), 64'd0);
    repeat (3) @(posedge c_clk);
    #1;
    chk("unexp_err_held", 64'(bus.err_unexpected), 64'd1);

    // Reset during SEND2, then a late response for the abandoned tag
    issue(CMD_ADD, 32'h11, 32'h22, 2'd0, "rst_op");
    reset = 1'b1;
    #1;
    chk("midrst_req", req_now(), 64'd0);
    chk("midrst_op_ready", 64'(bus.op_ready), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_err", 64'(bus.err_unexpected), 64'd0);
    @(negedge c_clk);
    reset = 1'b0;
    #1;
    chk("midrst_release_ready", 64'(bus.op_ready), 64'd1);
    @(posedge c_clk);
    #1;
    chk("midrst_idle_req", req_now(), 64'd0);
    inject(RESP_OK, 32'h33, 2'd0);
    chk("abandoned_tag_err", 64'(bus.err_unexpected), 64'd1);
    chk("abandoned_no_push", 64'(bus.rsp_valid), 64'd0);
    issue(CMD_SUB, 32'h5, 32'h3, 2'd0, "post_rst");
    respond(RESP_OK, 32'h2, 2'd0, CMD_SUB);
    wait_drain("post_rst");

    repeat (3) @(posedge c_clk);
    #1;
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc2_port_master.md
CALC2_PORT_MASTER -- requirements
Module: calc2_port_master

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of ops awaiting a response (1..4, bounded by the 2-bit tag).
REQ-002 The block SHALL have parameter RSP_DEPTH, default 4, meaning the number of response-FIFO entries (must be >= MAX_OUTSTANDING).
REQ-003 c_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op_valid  in  1  an upstream op is offered.
REQ-006 op_ready  out  1  the block accepts the op this cycle.
REQ-007 op_cmd  in  4  calculator command: ADD 4'h1, SUB 4'h2, SHL 4'h5, SHR 4'h6.
REQ-008 op_data1 / op_data2  in  32 each  operand 1 / operand 2.
REQ-009 req_cmd_out / req_data_out / req_tag_out  out  4 / 32 / 2  drive one calc2 port (reqN_cmd_in/data_in/tag_in).
REQ-010 out_resp / out_data / out_tag  in  2 / 32 / 2  the same port's calc2 response (out_respN/out_dataN/out_tagN).
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  downstream result handshake.
REQ-012 rsp_resp / rsp_data / rsp_tag / rsp_cmd  out  2 / 32 / 2 / 4  result code, data, tag, and echoed command.
REQ-013 err_unexpected  out  1  sticky flag: a response arrived carrying a tag that is not outstanding.

Function
REQ-014 The issue FSM SHALL have the states IDLE, SEND1 and SEND2.
REQ-015 op_ready SHALL be 1 only in IDLE or SEND2, when a free tag exists and outstanding < MAX_OUTSTANDING and outstanding + FIFO occupancy < RSP_DEPTH.
REQ-016 The handshake op_valid & op_ready SHALL capture op_cmd/op_data1/op_data2, allocate the lowest-numbered free tag, and move the FSM to SEND1.
REQ-017 In SEND1 the block SHALL drive req_cmd_out=cmd, req_data_out=data1, req_tag_out=tag, then move to SEND2.
REQ-018 In SEND2 the block SHALL drive req_cmd_out=0, req_data_out=data2, req_tag_out=tag, then move to SEND1 if a new op was accepted that cycle, otherwise to IDLE.
REQ-019 In IDLE the request outputs SHALL be cmd 0, data 0, tag 0.
REQ-020 Latency SHALL be: SEND1 in cycle N+1 for an op accepted in cycle N; back-to-back throughput of one op per 2 cycles.
REQ-021 The block SHALL keep a per-tag table of busy bit and command; the busy bit is set at accept.
REQ-022 A cycle with out_resp != 0 and out_tag busy SHALL clear that busy bit and push {out_resp, out_data, out_tag, table cmd} into the FIFO.
REQ-023 A tag freed in cycle N SHALL be allocatable no earlier than cycle N+1.
REQ-024 A response with a non-busy tag SHALL be dropped and SHALL set err_unexpected, which holds until reset.
REQ-025 rsp_* SHALL present the FIFO head; rsp_valid = FIFO not empty; the entry is popped when rsp_valid & rsp_ready.
REQ-026 A simultaneous push and pop on a full FIFO SHALL be legal; the credit rule of REQ-015 guarantees no overflow.
REQ-027 The FIFO read/write pointers SHALL wrap modulo RSP_DEPTH.
REQ-028 Results SHALL be delivered in arrival order, not issue order.

Reset
REQ-029 While reset is asserted: FSM=IDLE; req_cmd_out, req_data_out, req_tag_out = 0; all tags free; FIFO empty; rsp_valid=0; rsp_* = 0; err_unexpected=0; op_ready=0.
REQ-030 Reset asserted mid-SEND1/SEND2 SHALL abandon the op immediately, with no further request-output activity.
REQ-031 Responses for abandoned tags arriving after reset SHALL be treated as unexpected per REQ-024.

Structure
REQ-032 The shared package calc2_pkg SHALL hold the cmd constants (NOP, ADD, SUB, SHL, SHR), the response codes (NONE 0, OK 1, OVF/INVALID 2, INTERNAL 3), the FSM state enum, and the rsp_entry_t struct.
REQ-033 The FIFO SHALL be the sub-module calc2_rsp_fifo, parameterised by depth and carrying rsp_entry_t.

Verification
REQ-034 ADD 0x56,0x103 -> SEND1 (1,0x56,tag0) then SEND2 (0,0x103,tag0); inject resp 1/0x159/tag0 -> rsp_* = 1,0x159,0,cmd 1.
REQ-035 SUB 0x158,0x12 then SUB 0x18,0x32 back-to-back -> tags 0,1; responses 0x146 resp 1 and resp 2 (underflow), each with the matching tag and cmd 2.
REQ-036 Five ops with no responses -> tags 0..3 issued, op_ready=0 for the fifth; a response on tag2 -> fifth op gets tag2 one cycle later.
REQ-037 Hold rsp_ready=0 with 4 responses queued -> op_ready stays 0; then rsp_ready=1 -> 4 pops in order.
REQ-038 Inject resp 1 on tag3 while idle -> FIFO unchanged, err_unexpected=1 and held.
REQ-039 Assert reset during SEND2 -> all outputs 0 in the same cycle; after release op_ready=1 and tag0 is allocated first.
